// File: rtl/mem_arb_pkg.sv
// Shared encodings for the I/D memory arbiter: FSM states, grant owner and word-alignment mask.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } arb_state_t;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } grant_t;

   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/mem_arb_priority.sv
// Winner select between fetch and data ports with a starvation counter that
// forces a fetch grant after STARVE_MAX back-to-back data grants.
module mem_arb_priority
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 3
) (
   input  logic   clk_i,
   input  logic   reset_i,
   input  logic   arb_en_i,
   input  logic   i_req_i,
   input  logic   d_req_i,
   output logic   grant_valid_o,
   output grant_t grant_o
);

   localparam int            SW   = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

   logic [SW-1:0] starve_q;
   logic [SW-1:0] starve_d;

   always_comb begin
      grant_valid_o = i_req_i | d_req_i;
      grant_o       = GNT_D;
      if (i_req_i && (!d_req_i || (starve_q == SMAX))) begin
         grant_o = GNT_I;
      end

      starve_d = starve_q;
      if (arb_en_i) begin
         // An idle cycle without a pending fetch means nobody is being starved.
         if (!i_req_i || (grant_o == GNT_I)) begin
            starve_d = '0;
         end else if (starve_q != SMAX) begin
            starve_d = starve_q + SW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access, one access at a time
// with LATENCY wait cycles. Optional grant/wait statistics when MEM_ARB_STATS_EN is defined.
//
// state | meaning
// IDLE  | arbitrate pending requests, latch the winner
// BUSY  | drive memory for LATENCY cycles; strobe/capture in the last one
// DONE  | one-cycle ready pulse to the granted port
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int LATENCY    = 2,
   parameter int STARVE_MAX = 3
) (
   input  logic        clock_me,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ready,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ready,
   output logic [31:0] d_rdata,
   output logic [31:0] m_addr,
   output logic        m_wmem,
   output logic [31:0] m_in,
   input  logic [31:0] m_out
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [31:0] stat_i_grants,
   output logic [31:0] stat_d_grants,
   output logic [31:0] stat_wait_cycles
`endif
);

   localparam int            CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] LOAD = CW'(LATENCY - 1);

   arb_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   grant_t        gnt_q, gnt_d;
   logic [31:0]   addr_q, addr_d;
   logic          we_q, we_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   i_rdata_q, i_rdata_d;
   logic [31:0]   d_rdata_q, d_rdata_d;

   logic   arb_en;
   logic   win_valid;
   grant_t win_gnt;
   logic   last_wait;

   assign arb_en    = (state_q == ST_IDLE);
   assign last_wait = (state_q == ST_BUSY) && (cnt_q == '0);

   mem_arb_priority #(
      .STARVE_MAX(STARVE_MAX)
   ) u_prio (
      .clk_i        (clock_me),
      .reset_i      (reset),
      .arb_en_i     (arb_en),
      .i_req_i      (i_req),
      .d_req_i      (d_req),
      .grant_valid_o(win_valid),
      .grant_o      (win_gnt)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      gnt_d     = gnt_q;
      addr_d    = addr_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (win_valid) begin
               gnt_d   = win_gnt;
               cnt_d   = LOAD;
               state_d = ST_BUSY;
               if (win_gnt == GNT_D) begin
                  addr_d  = d_addr;
                  we_d    = d_we;
                  wdata_d = d_wdata;
               end else begin
                  addr_d = i_addr;
                  we_d   = 1'b0;
               end
            end
         end
         ST_BUSY: begin
            if (cnt_q == '0) begin
               if (gnt_q == GNT_I) begin
                  i_rdata_d = m_out;
               end else if (!we_q) begin
                  d_rdata_d = m_out;
               end
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock_me) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         gnt_q     <= GNT_I;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gnt_q     <= gnt_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   // Reset gates the strobe combinationally so an in-flight store is dropped.
   assign m_wmem  = last_wait && (gnt_q == GNT_D) && we_q && !reset;
   assign m_addr  = addr_q & WORD_MASK;
   assign m_in    = wdata_q;
   assign i_ready = (state_q == ST_DONE) && (gnt_q == GNT_I);
   assign d_ready = (state_q == ST_DONE) && (gnt_q == GNT_D);
   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;

`ifdef MEM_ARB_STATS_EN
   logic [31:0] st_i_q, st_d_q, st_w_q;
   logic        i_served, d_served, any_wait;

   assign i_served = (state_q != ST_IDLE) && (gnt_q == GNT_I);
   assign d_served = (state_q != ST_IDLE) && (gnt_q == GNT_D);
   assign any_wait = (i_req && !i_served) || (d_req && !d_served);

   always_ff @(posedge clock_me) begin
      if (reset) begin
         st_i_q <= '0;
         st_d_q <= '0;
         st_w_q <= '0;
      end else begin
         if (arb_en && win_valid && (win_gnt == GNT_I)) st_i_q <= st_i_q + 32'd1;
         if (arb_en && win_valid && (win_gnt == GNT_D)) st_d_q <= st_d_q + 32'd1;
         if (any_wait)                                  st_w_q <= st_w_q + 32'd1;
      end
   end

   assign stat_i_grants    = st_i_q;
   assign stat_d_grants    = st_d_q;
   assign stat_wait_cycles = st_w_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, random episodes against a
// transaction-level model, starvation sequence and reset during a store strobe.
module tb_mem_arbiter;

   localparam int LAT = 2;
   localparam int SM  = 3;

   logic        clock_me = 1'b0;
   logic        reset    = 1'b0;
   logic        i_req    = 1'b0;
   logic [31:0] i_addr   = '0;
   logic        i_ready;
   logic [31:0] i_rdata;
   logic        d_req    = 1'b0;
   logic        d_we     = 1'b0;
   logic [31:0] d_addr   = '0;
   logic [31:0] d_wdata  = '0;
   logic        d_ready;
   logic [31:0] d_rdata;
   logic [31:0] m_addr;
   logic        m_wmem;
   logic [31:0] m_in;
   logic [31:0] m_out;
`ifdef MEM_ARB_STATS_EN
   logic [31:0] stat_i_grants, stat_d_grants, stat_wait_cycles;
`endif

   mem_arbiter #(.LATENCY(LAT), .STARVE_MAX(SM)) dut (
      .clock_me(clock_me), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_rdata(d_rdata),
      .m_addr(m_addr), .m_wmem(m_wmem), .m_in(m_in), .m_out(m_out)
`ifdef MEM_ARB_STATS_EN
      , .stat_i_grants(stat_i_grants), .stat_d_grants(stat_d_grants),
      .stat_wait_cycles(stat_wait_cycles)
`endif
   );

   always #5 clock_me = ~clock_me;

   // Memory environment: combinational read, write on the strobe edge.
   logic [31:0] mem [256];
   assign m_out = mem[m_addr[9:2]];
   always @(posedge clock_me) begin
      if (m_wmem) mem[m_addr[9:2]] <= m_in;
   end

   // Reference model state
   logic [31:0] ref_mem [256];
   logic [31:0] model_i, model_d;
   int          model_starve;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        ri, rd, we;
      logic [31:0] ia, da, wd;
      logic [31:0] exp_i, exp_d;
   } vec_t;
   vec_t tbl [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clock_me);
      reset = 1'b1; i_req = 1'b0; d_req = 1'b0;
      repeat (2) @(negedge clock_me);
      reset = 1'b0;
      model_i = '0; model_d = '0; model_starve = 0;
   endtask

   // One episode: fetch and/or data request raised together in an IDLE cycle,
   // each held until its ready. Expectations come from the transaction model.
   task automatic episode(input logic ri, input logic rd, input logic we,
                          input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                          output logic [31:0] ird, output logic [31:0] drd);
      logic        first_d, take_d, ireq_now;
      int          nslot, i_due, d_due, i_strb, d_strb, last;
      logic [31:0] prev_i, i_at_d;
      first_d = rd && !(ri && model_starve == SM);
      nslot   = (ri && rd) ? 2 : 1;
      i_due = -100; d_due = -100; i_strb = -100; d_strb = -100;
      prev_i = model_i;
      ird = '0; drd = '0;
      for (int s = 0; s < nslot; s++) begin
         take_d   = (s == 0) ? first_d : !first_d;
         ireq_now = ri && ((s == 0) || first_d);
         if (take_d) begin
            d_strb = s * (LAT + 2) + LAT;
            d_due  = d_strb + 1;
            if (we) ref_mem[da[9:2]] = wd;
            else    model_d = ref_mem[da[9:2]];
            if (!ireq_now)         model_starve = 0;
            else if (model_starve < SM) model_starve++;
         end else begin
            i_strb  = s * (LAT + 2) + LAT;
            i_due   = i_strb + 1;
            model_i = ref_mem[ia[9:2]];
            model_starve = 0;
         end
      end
      i_at_d = first_d ? prev_i : model_i;
      last   = (i_due > d_due) ? i_due : d_due;

      @(negedge clock_me);
      i_req = ri; i_addr = ia; d_req = rd; d_we = we; d_addr = da; d_wdata = wd;
      for (int k = 1; k <= last; k++) begin
         @(negedge clock_me);
         if (k == i_strb) check("fetch m_addr", m_addr, ia & 32'hFFFF_FFFC);
         if (k == d_strb) check("data m_addr", m_addr, da & 32'hFFFF_FFFC);
         if (k == d_strb && we) check("m_in", m_in, wd);
         check("m_wmem", {31'b0, m_wmem}, {31'b0, (k == d_strb) && we});
         check("i_ready", {31'b0, i_ready}, {31'b0, k == i_due});
         check("d_ready", {31'b0, d_ready}, {31'b0, k == d_due});
         if (k == i_due) begin
            check("i_rdata", i_rdata, model_i);
            ird = i_rdata; i_req = 1'b0;
         end
         if (k == d_due) begin
            check("d_rdata", d_rdata, model_d);
            check("i_rdata hold", i_rdata, i_at_d);
            drd = d_rdata; d_req = 1'b0;
         end
      end
      i_req = 1'b0; d_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ird, drd;
      logic [31:0] old_w;
      int          n;
      logic        due, exp_is_i;

      tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h8,   32'h0,   32'h0,        32'h8C010064, 32'h0};
      tbl[1] = '{1'b0, 1'b1, 1'b1, 32'h0,   32'h190, 32'hDEADBEEF, 32'h0,        32'h0};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h190, 32'h0,        32'h0,        32'hDEADBEEF};
      tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h193, 32'h0,        32'h0,        32'hDEADBEEF};
      tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h191, 32'h20,  32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF};
      tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h20,  32'h8,   32'h0,        32'h12345678, 32'h8C010064};

      for (int i = 0; i < 256; i++) begin
         mem[i]     <= 32'hA5A5_0000 | 32'(i);
         ref_mem[i]  = 32'hA5A5_0000 | 32'(i);
      end
      mem[2]     <= 32'h8C010064;
      ref_mem[2]  = 32'h8C010064;

      do_reset();
      @(negedge clock_me);
      check("rst i_ready", {31'b0, i_ready}, 32'h0);
      check("rst d_ready", {31'b0, d_ready}, 32'h0);
      check("rst i_rdata", i_rdata, 32'h0);
      check("rst d_rdata", d_rdata, 32'h0);
      check("rst m_wmem",  {31'b0, m_wmem}, 32'h0);
      check("rst m_addr",  m_addr, 32'h0);
      check("rst m_in",    m_in, 32'h0);

      for (int t = 0; t < 6; t++) begin
         episode(tbl[t].ri, tbl[t].rd, tbl[t].we, tbl[t].ia, tbl[t].da, tbl[t].wd, ird, drd);
         if (tbl[t].ri) check("tbl i_rdata", ird, tbl[t].exp_i);
         if (tbl[t].rd) check("tbl d_rdata", drd, tbl[t].exp_d);
      end

      for (int r = 0; r < 40; r++) begin
         logic [1:0] sel;
         sel = 2'($urandom_range(1, 3));
         episode(sel[0], sel[1], 1'($urandom_range(0, 1)),
                 $urandom() & 32'h3F, $urandom() & 32'h3F, $urandom(), ird, drd);
      end

      // Sustained contention: D,D,D,I repeating, one ready every LAT+2 cycles.
      do_reset();
      @(negedge clock_me);
      i_req = 1'b1; i_addr = 32'h8; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4;
      for (int k = 1; k <= 8 * (LAT + 2) - 1; k++) begin
         @(negedge clock_me);
         due      = (k >= LAT + 1) && ((k - (LAT + 1)) % (LAT + 2) == 0);
         n        = (k - (LAT + 1)) / (LAT + 2);
         exp_is_i = due && (n % (SM + 1) == SM);
         check("contend i_ready", {31'b0, i_ready}, {31'b0, exp_is_i});
         check("contend d_ready", {31'b0, d_ready}, {31'b0, due && !exp_is_i});
         if (exp_is_i)  check("contend i_rdata", i_rdata, ref_mem[2]);
         if (due && !exp_is_i) check("contend d_rdata", d_rdata, ref_mem[1]);
      end
      i_req = 1'b0; d_req = 1'b0;
      model_i = ref_mem[2]; model_d = ref_mem[1]; model_starve = 0;
`ifdef MEM_ARB_STATS_EN
      @(negedge clock_me);
      check("stat_d_grants", stat_d_grants, 32'd6);
      check("stat_i_grants", stat_i_grants, 32'd2);
`endif

      // Reset landing on the store strobe cycle must suppress the write.
      @(negedge clock_me);
      old_w = ref_mem[16];
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hCAFEF00D;
      repeat (LAT) @(negedge clock_me);
      check("pre-reset strobe", {31'b0, m_wmem}, 32'h1);
      reset = 1'b1; d_req = 1'b0;
      #1;
      check("reset gates m_wmem", {31'b0, m_wmem}, 32'h0);
      @(negedge clock_me);
      check("abort d_ready", {31'b0, d_ready}, 32'h0);
      check("abort d_rdata", d_rdata, 32'h0);
      check("abort mem", mem[16], old_w);
      reset = 1'b0;
      model_i = '0; model_d = '0; model_starve = 0;
      episode(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, ird, drd);
      check("post-abort fetch", ird, old_w);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
